// File: rtl/nop_insert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nop_insert_ctrl
// Description : RAW hazard scheduler placed between ID and EX of an in-order,
//               non-forwarding pipeline. It records the destinations of
//               in-flight writers in a shift scoreboard. When the ID
//               instruction reads a pending register, the scheduler holds
//               IF/ID and feeds exactly enough NOP bubbles into EX for the
//               write to complete.
//               Optional NOP statistics counter: define NOP_INSERT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nop_insert_ctrl #(
  parameter int HAZ_DEPTH = 3,   // EX entry to register-file write, 1..7
  parameter int STAT_W    = 16   // width of the injected-NOP counter
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  output logic              issue,
  output logic              stall,
  output logic              nop_inject,
  output logic              nop_cnt_en,
  output logic [STAT_W-1:0] nop_total,
  output logic              busy
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  // funct3/funct7 and immediates have no bearing on hazards
  logic unused_fields;
  assign unused_fields = ^{id_instr[31:25], id_instr[14:12]};

  logic writes_rd;
  logic reads_rs1;
  logic reads_rs2;

  // Classify the opcode by which register operands it touches
  always_comb begin
    writes_rd = 1'b0;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD: begin
        writes_rd = 1'b1;
        reads_rs1 = 1'b1;
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      OPC_STORE: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Scoreboard: entry 0 holds the most recently issued writer
  logic [HAZ_DEPTH-1:0] sb_v;
  logic [4:0]           sb_rd [HAZ_DEPTH];
  logic                 sb_load;

  // x0 writes are never tracked since x0 cannot carry a dependency
  assign sb_load = issue && writes_rd && (rd != 5'd0);

  // Valid bits shift every cycle and clear on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_v <= '0;
    end else begin
      for (int k = HAZ_DEPTH - 1; k > 0; k--) begin
        sb_v[k] <= sb_v[k-1];
      end
      sb_v[0] <= sb_load;
    end
  end

  // Register tags shift freely; they only matter alongside a set valid bit
  always_ff @(posedge clock) begin
    for (int k = HAZ_DEPTH - 1; k > 0; k--) begin
      sb_rd[k] <= sb_rd[k-1];
    end
    sb_rd[0] <= rd;
  end

  logic       hit;
  logic [2:0] hit_idx;
  logic [2:0] need;

  // Find the youngest matching writer; scanning old-to-young lets it win
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = HAZ_DEPTH - 1; i >= 0; i--) begin
      if (sb_v[i] &&
          ((reads_rs1 && (rs1 != 5'd0) && (sb_rd[i] == rs1)) ||
           (reads_rs2 && (rs2 != 5'd0) && (sb_rd[i] == rs2)))) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  assign need = 3'(HAZ_DEPTH) - hit_idx;

  logic [0:0] state;
  logic [0:0] next_state;
  logic [2:0] rem;
  logic [2:0] next_rem;

  // State and remaining-bubble registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
      rem   <= 3'd0;
    end else begin
      state <= next_state;
      rem   <= next_rem;
    end
  end

  // A single-bubble hazard is handled entirely from RUN; longer ones park in STALL
  always_comb begin
    next_state = state;
    next_rem   = rem;
    case (state)
      ST_RUN: begin
        if (id_valid && hit && (need != 3'd1)) begin
          next_state = ST_STALL;
          next_rem   = need - 3'd1;
        end
      end
      ST_STALL: begin
        next_rem = rem - 3'd1;
        if (rem == 3'd1) begin
          next_state = ST_RUN;
        end
      end
      default: begin
        next_state = ST_RUN;
        next_rem   = 3'd0;
      end
    endcase
  end

  // Pipeline controls; all quiet while reset is held
  always_comb begin
    issue      = 1'b0;
    stall      = 1'b0;
    nop_inject = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (id_valid) begin
            if (hit) begin
              stall      = 1'b1;
              nop_inject = 1'b1;
            end else begin
              issue = 1'b1;
            end
          end
        end
        ST_STALL: begin
          stall      = 1'b1;
          nop_inject = 1'b1;
          busy       = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign nop_cnt_en = nop_inject;

`ifdef NOP_INSERT_STATS_EN
  logic [STAT_W-1:0] stat_cnt;

  // Saturating count of injected bubbles
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_cnt <= '0;
    end else if (nop_inject && (stat_cnt != {STAT_W{1'b1}})) begin
      stat_cnt <= stat_cnt + STAT_W'(1);
    end
  end

  assign nop_total = stat_cnt;
`else
  assign nop_total = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nop_insert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nop_insert_ctrl
// Description : Directed self-checking bench for nop_insert_ctrl
//               (HAZ_DEPTH=3, STAT_W=4). Honours NOP_INSERT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nop_insert_ctrl;

  localparam int HAZ_DEPTH = 3;
  localparam int STAT_W    = 4;

  // {issue, stall, nop_inject, nop_cnt_en, busy}
  localparam logic [4:0] P_ISSUE     = 5'b10000;
  localparam logic [4:0] P_NOP_RUN   = 5'b01110;
  localparam logic [4:0] P_NOP_STALL = 5'b01111;
  localparam logic [4:0] P_IDLE      = 5'b00000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              id_valid = 1'b0;
  logic [31:0]       id_instr = 32'h0;
  logic              issue;
  logic              stall;
  logic              nop_inject;
  logic              nop_cnt_en;
  logic [STAT_W-1:0] nop_total;
  logic              busy;
  logic [4:0]        flags;

  int checks = 0;
  int errors = 0;
  int exp_total = 0;

  always #5 clock = ~clock;

  nop_insert_ctrl #(
    .HAZ_DEPTH (HAZ_DEPTH),
    .STAT_W    (STAT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .issue      (issue),
    .stall      (stall),
    .nop_inject (nop_inject),
    .nop_cnt_en (nop_cnt_en),
    .nop_total  (nop_total),
    .busy       (busy)
  );

  assign flags = {issue, stall, nop_inject, nop_cnt_en, busy};

  // Instruction encoders
  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] f_op(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] f_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] f_jal(input logic [4:0] rd);
    return {20'h00100, rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected counter model
  task automatic note_nops(input int n);
`ifdef NOP_INSERT_STATS_EN
    exp_total = exp_total + n;
    if (exp_total > (1 << STAT_W) - 1) exp_total = (1 << STAT_W) - 1;
`else
    exp_total = 0;
`endif
  endtask

  // One cycle: present inputs shortly after the edge, settle, then sample
  task automatic drive(input logic v, input logic [31:0] ins);
    @(posedge clock);
    #1;
    id_valid = v;
    id_instr = ins;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset    = 1'b1;
    id_valid = 1'b1;
    id_instr = f_op(7'h00, 5'd2, 5'd1, 5'd1);
    #1;
    check("rst_outputs", 32'(flags), 32'(P_IDLE));
    @(posedge clock);
    #1;
    reset     = 1'b0;
    id_valid  = 1'b0;
    exp_total = 0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_total", 32'(nop_total), 32'd0);
  endtask

  // Hold an instruction in ID through n bubbles, then expect it to issue
  task automatic run_dep(input string tag, input logic [31:0] ins, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, ins);
      check(tag, 32'(flags), (k == 0) ? 32'(P_NOP_RUN) : 32'(P_NOP_STALL));
    end
    note_nops(n);
    drive(1'b1, ins);
    check(tag, 32'(flags), 32'(P_ISSUE));
  endtask

  task automatic issue_one(input string tag, input logic [31:0] ins);
    drive(1'b1, ins);
    check(tag, 32'(flags), 32'(P_ISSUE));
  endtask

  initial begin
    do_reset();

    // Adjacent dependency: 3 bubbles
    issue_one("adj_addi", f_addi(5'd1, 5'd0, 12'd5));
    run_dep("adj_add", f_op(7'h00, 5'd2, 5'd1, 5'd1), 3);
    check("adj_total", 32'(nop_total), 32'(exp_total));

    // Distance 2, both operands pending: youngest match wins
    do_reset();
    issue_one("d2_addi1", f_addi(5'd1, 5'd0, 12'd1));
    issue_one("d2_addi3", f_addi(5'd3, 5'd0, 12'd2));
    run_dep("d2_sub", f_op(7'h20, 5'd4, 5'd1, 5'd3), 3);

    // Distance 2, middle independent: 2 bubbles
    do_reset();
    issue_one("d2b_addi1", f_addi(5'd1, 5'd0, 12'd1));
    issue_one("d2b_addi5", f_addi(5'd5, 5'd0, 12'd2));
    run_dep("d2b_sub", f_op(7'h20, 5'd4, 5'd1, 5'd3), 2);
    check("d2b_total", 32'(nop_total), 32'(exp_total));

    // Distance 3 with idle gaps: single bubble, idle cycles are not NOPs
    do_reset();
    issue_one("d3_addi1", f_addi(5'd1, 5'd0, 12'd1));
    drive(1'b0, f_op(7'h00, 5'd2, 5'd1, 5'd1));
    check("d3_idle0", 32'(flags), 32'(P_IDLE));
    drive(1'b0, f_op(7'h00, 5'd2, 5'd1, 5'd1));
    check("d3_idle1", 32'(flags), 32'(P_IDLE));
    run_dep("d3_add", f_op(7'h00, 5'd2, 5'd1, 5'd1), 1);
    check("d3_total", 32'(nop_total), 32'(exp_total));

    // Writer has fully retired: no bubble
    do_reset();
    issue_one("d4_addi1", f_addi(5'd1, 5'd0, 12'd1));
    for (int k = 0; k < 3; k++) drive(1'b0, 32'h0);
    issue_one("d4_add", f_op(7'h00, 5'd2, 5'd1, 5'd1));

    // x0 never matches; LUI and JAL read nothing
    do_reset();
    issue_one("x0_addi", f_addi(5'd0, 5'd0, 12'd1));
    issue_one("x0_add", f_op(7'h00, 5'd2, 5'd0, 5'd0));
    issue_one("lui_a", f_lui(5'd1));
    issue_one("lui_b", f_lui(5'd1));
    issue_one("jal", f_jal(5'd1));

    // Store reading a pending rs2, then a store that writes nothing
    do_reset();
    issue_one("st_addi7", f_addi(5'd7, 5'd0, 12'd1));
    run_dep("st_sw", f_sw(5'd7, 5'd2, 12'd0), 3);
    issue_one("st_add9", f_op(7'h00, 5'd9, 5'd8, 5'd8));

    // Reset in place of the second bubble abandons the stall
    do_reset();
    issue_one("rm_addi1", f_addi(5'd1, 5'd0, 12'd1));
    drive(1'b1, f_op(7'h00, 5'd2, 5'd1, 5'd1));
    check("rm_nop1", 32'(flags), 32'(P_NOP_RUN));
    note_nops(1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rm_in_reset", 32'(flags), 32'(P_IDLE));
    @(posedge clock);
    #1;
    reset     = 1'b0;
    exp_total = 0;
    #1;
    check("rm_after_flags", 32'(flags), 32'(P_ISSUE));
    check("rm_after_total", 32'(nop_total), 32'd0);

    // Twenty adjacent hazards: counter saturates (or stays 0 without stats)
    do_reset();
    for (int h = 0; h < 20; h++) begin
      issue_one("sat_addi", f_addi(5'd1, 5'd0, 12'd3));
      run_dep("sat_add", f_op(7'h00, 5'd2, 5'd1, 5'd1), 3);
      check("sat_total", 32'(nop_total), 32'(exp_total));
    end
`ifdef NOP_INSERT_STATS_EN
    check("sat_final", 32'(nop_total), 32'd15);
`else
    check("sat_final", 32'(nop_total), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
